// File: rtl/handshake_pkg.sv
// ---------------------------------------------------------------------------
// handshake_pkg
// Shared sizing helpers for the handshake buffer family.
//   ptr_w(slots) : bits needed to index 0..slots-1 (never less than 1)
//   cnt_w(slots) : bits needed to hold an occupancy of 0..slots
// ---------------------------------------------------------------------------
package handshake_pkg;

   function automatic int ptr_w(input int slots);
      if (slots > 1) begin
         return $clog2(slots);
      end else begin
         return 1;
      end
   endfunction

   function automatic int cnt_w(input int slots);
      return $clog2(slots + 1);
   endfunction

endpackage

// File: rtl/handshake_fifo_ptr.sv
// ---------------------------------------------------------------------------
// handshake_fifo_ptr
// Modulo-NUM_SLOTS wrap counter used for the read and write pointers.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-low reset, clears the pointer to 0
//   adv  : advance the pointer by one this cycle
//   ptr  : current pointer, wraps from NUM_SLOTS-1 to 0
// ---------------------------------------------------------------------------
module handshake_fifo_ptr
   import handshake_pkg::*;
#(
   parameter int NUM_SLOTS = 4,
   parameter int PTR_W     = ptr_w(NUM_SLOTS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             adv,
   output logic [PTR_W-1:0] ptr
);

   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NUM_SLOTS - 1);

   // Pointer register; explicit wrap so non-power-of-two depths work.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr <= {PTR_W{1'b0}};
      end else if (adv) begin
         if (ptr == LAST_PTR) begin
            ptr <= {PTR_W{1'b0}};
         end else begin
            ptr <= ptr + PTR_W'(1);
         end
      end
   end

endmodule

// File: rtl/handshake_fifo_buffer.sv
// ---------------------------------------------------------------------------
// handshake_fifo_buffer
// Valid/ready FIFO buffer of NUM_SLOTS entries (any depth 2..64).
// Optional build macro: HANDSHAKE_FIFO_BYPASS_EN -- when defined, an empty
// buffer falls through combinationally (outs = ins, no storage write).
// Ports:
//   clk, rst    : clock; asynchronous active-low reset
//   ins         : upstream payload
//   ins_valid   : upstream payload valid
//   ins_ready   : buffer not full (depends only on registered count)
//   outs        : head payload, zero when nothing valid
//   outs_valid  : head payload valid
//   outs_ready  : downstream accepts head
//   count       : registered occupancy
// ---------------------------------------------------------------------------
module handshake_fifo_buffer
   import handshake_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_SLOTS  = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [DATA_WIDTH-1:0]         ins,
   input  logic                          ins_valid,
   output logic                          ins_ready,
   output logic [DATA_WIDTH-1:0]         outs,
   output logic                          outs_valid,
   input  logic                          outs_ready,
   output logic [cnt_w(NUM_SLOTS)-1:0]   count
);

   localparam int                PTR_W    = ptr_w(NUM_SLOTS);
   localparam int                CNT_W    = cnt_w(NUM_SLOTS);
   localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(NUM_SLOTS);
   localparam logic [CNT_W-1:0]  ZERO_CNT = {CNT_W{1'b0}};

   logic [DATA_WIDTH-1:0] storage [NUM_SLOTS];
   logic [PTR_W-1:0]      rd_ptr;
   logic [PTR_W-1:0]      wr_ptr;
   logic                  empty;
   logic                  push;
   logic                  pop;
   logic                  bypass;
   logic                  wr_en;
   logic                  rd_adv;

   assign empty     = (count == ZERO_CNT);
   assign ins_ready = (count != FULL_CNT);
   assign push      = ins_valid && ins_ready;
   assign pop       = outs_valid && outs_ready;
   // A bypassed transfer touches neither storage, pointers nor count.
   assign wr_en     = push && !bypass;
   assign rd_adv    = pop && !bypass;

`ifdef HANDSHAKE_FIFO_BYPASS_EN
   assign bypass = empty && ins_valid && outs_ready;

   // Head selection with fall-through of ins while empty.
   always_comb begin
      outs_valid = !empty || ins_valid;
      if (!empty) begin
         outs = storage[rd_ptr];
      end else if (ins_valid) begin
         outs = ins;
      end else begin
         outs = {DATA_WIDTH{1'b0}};
      end
   end
`else
   assign bypass = 1'b0;

   // Head selection; zero when empty so no stale payload leaks out.
   always_comb begin
      outs_valid = !empty;
      if (!empty) begin
         outs = storage[rd_ptr];
      end else begin
         outs = {DATA_WIDTH{1'b0}};
      end
   end
`endif

   // Storage write; deliberately not reset, contents are gated by count.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         storage[wr_ptr] <= ins;
      end
   end

   // Occupancy counter; simultaneous push and pop holds.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= ZERO_CNT;
      end else begin
         case ({wr_en, rd_adv})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   handshake_fifo_ptr #(.NUM_SLOTS(NUM_SLOTS), .PTR_W(PTR_W)) u_rd_ptr (
      .clk (clk),
      .rst (rst),
      .adv (rd_adv),
      .ptr (rd_ptr)
   );

   handshake_fifo_ptr #(.NUM_SLOTS(NUM_SLOTS), .PTR_W(PTR_W)) u_wr_ptr (
      .clk (clk),
      .rst (rst),
      .adv (wr_en),
      .ptr (wr_ptr)
   );

endmodule

// File: tb/tb_handshake_fifo_buffer.sv
// ---------------------------------------------------------------------------
// tb_handshake_fifo_buffer
// Bench for handshake_fifo_buffer: instance a (34-bit, 4 slots) and
// instance b (34-bit, 3 slots). Honors HANDSHAKE_FIFO_BYPASS_EN.
// ---------------------------------------------------------------------------
module tb_handshake_fifo_buffer;

`ifdef HANDSHAKE_FIFO_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   localparam logic [33:0] CONST_VAL = 34'h150348F47;

   logic        clk = 1'b0;
   logic        rst = 1'b0;

   logic [33:0] a_ins = 34'd0;
   logic        a_ins_valid = 1'b0;
   logic        a_ins_ready;
   logic [33:0] a_outs;
   logic        a_outs_valid;
   logic        a_outs_ready = 1'b0;
   logic [2:0]  a_count;

   logic [33:0] b_ins = 34'd0;
   logic        b_ins_valid = 1'b0;
   logic        b_ins_ready;
   logic [33:0] b_outs;
   logic        b_outs_valid;
   logic        b_outs_ready = 1'b0;
   logic [1:0]  b_count;

   int total_cnt = 0;
   int bad_cnt   = 0;
   int a_pops    = 0;
   int b_pops    = 0;
   int b_max     = 0;
   bit b_done    = 1'b0;
   logic [33:0] a_q [$];
   logic [33:0] b_q [$];

   always #5 clk = ~clk;

   handshake_fifo_buffer #(.DATA_WIDTH(34), .NUM_SLOTS(4)) dut_a (
      .clk(clk), .rst(rst),
      .ins(a_ins), .ins_valid(a_ins_valid), .ins_ready(a_ins_ready),
      .outs(a_outs), .outs_valid(a_outs_valid), .outs_ready(a_outs_ready),
      .count(a_count)
   );

   handshake_fifo_buffer #(.DATA_WIDTH(34), .NUM_SLOTS(3)) dut_b (
      .clk(clk), .rst(rst),
      .ins(b_ins), .ins_valid(b_ins_valid), .ins_ready(b_ins_ready),
      .outs(b_outs), .outs_valid(b_outs_valid), .outs_ready(b_outs_ready),
      .count(b_count)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total_cnt++;
      if (got !== exp) begin
         bad_cnt++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Scoreboard for instance a: handshakes sampled mid-cycle.
   always @(negedge clk) begin
      if (!rst) begin
         a_q.delete();
      end else begin
         if (a_ins_valid && a_ins_ready) a_q.push_back(a_ins);
         if (a_outs_valid && a_outs_ready) begin
            if (a_q.size() == 0) begin
               check_eq("a_pop_empty", 64'd1, 64'd0);
            end else begin
               check_eq("a_order", a_outs, a_q.pop_front());
               a_pops++;
            end
         end
      end
   end

   // Scoreboard for instance b plus peak occupancy tracking.
   always @(negedge clk) begin
      if (!rst) begin
         b_q.delete();
      end else begin
         if (int'(b_count) > b_max) b_max = int'(b_count);
         if (b_ins_valid && b_ins_ready) b_q.push_back(b_ins);
         if (b_outs_valid && b_outs_ready) begin
            if (b_q.size() == 0) begin
               check_eq("b_pop_empty", 64'd1, 64'd0);
            end else begin
               check_eq("b_order", b_outs, b_q.pop_front());
               b_pops++;
            end
         end
      end
   end

   task automatic push_a(input logic [33:0] v);
      bit ok = 1'b0;
      a_ins = v;
      a_ins_valid = 1'b1;
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         if (a_ins_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check_eq("a_push_timeout", 64'd0, 64'd1);
      @(posedge clk); #1;
      a_ins_valid = 1'b0;
   endtask

   task automatic push_b(input logic [33:0] v);
      bit ok = 1'b0;
      b_ins = v;
      b_ins_valid = 1'b1;
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         if (b_ins_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check_eq("b_push_timeout", 64'd0, 64'd1);
      @(posedge clk); #1;
      b_ins_valid = 1'b0;
   endtask

   task automatic drain_a();
      a_outs_ready = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (a_count == 3'd0) break;
      end
      check_eq("a_drain", a_count, 64'd0);
      @(posedge clk); #1;
   endtask

   initial begin
      int base;
      // Reset state
      #2;
      check_eq("rst_count", a_count, 64'd0);
      check_eq("rst_ovalid", a_outs_valid, 64'd0);
      check_eq("rst_outs", a_outs, 64'd0);
      check_eq("rst_iready", a_ins_ready, 64'd1);
      repeat (2) @(posedge clk);
      #1;
      // First push lands on the first rising edge after release
      rst = 1'b1;
      a_ins = 34'h55;
      a_ins_valid = 1'b1;
      @(posedge clk); #1;
      a_ins_valid = 1'b0;
      check_eq("first_push_cnt", a_count, 64'd1);
      check_eq("first_push_outs", a_outs, 64'h55);
      drain_a();

      // Constant feed
      a_ins = CONST_VAL;
      a_ins_valid = 1'b1;
      a_outs_ready = 1'b1;
      #1;
      check_eq("feed_ovalid0", a_outs_valid, BYP ? 64'd1 : 64'd0);
      @(posedge clk); #1;
      for (int i = 0; i < 5; i++) begin
         check_eq("feed_ovalid", a_outs_valid, 64'd1);
         check_eq("feed_outs", a_outs, CONST_VAL);
         check_eq("feed_count", a_count, BYP ? 64'd0 : 64'd1);
         @(posedge clk); #1;
      end
      a_ins_valid = 1'b0;
      drain_a();

      // Fill and stall
      base = a_pops;
      a_outs_ready = 1'b0;
      for (int v = 1; v <= 4; v++) push_a(34'(v));
      check_eq("fill_count", a_count, 64'd4);
      check_eq("fill_iready", a_ins_ready, 64'd0);
      fork
         push_a(34'd5);
         begin
            for (int i = 0; i < 2; i++) begin
               check_eq("stall_outs", a_outs, 64'd1);
               check_eq("stall_count", a_count, 64'd4);
               @(posedge clk); #1;
            end
            a_outs_ready = 1'b1;
         end
      join
      for (int i = 0; i < 40; i++) begin
         if (a_pops >= base + 5) break;
         @(posedge clk); #1;
      end
      check_eq("fill_pops", a_pops - base, 64'd5);
      drain_a();

      // Simultaneous push and pop at count 2
      a_outs_ready = 1'b0;
      push_a(34'hA);
      push_a(34'hB);
      check_eq("sim_pre_cnt", a_count, 64'd2);
      a_ins = 34'hC;
      a_ins_valid = 1'b1;
      a_outs_ready = 1'b1;
      @(posedge clk); #1;
      a_ins_valid = 1'b0;
      a_outs_ready = 1'b0;
      check_eq("sim_count", a_count, 64'd2);
      check_eq("sim_head", a_outs, 64'hB);
      drain_a();

      // Empty-buffer transfer (fall-through only in the bypass build)
      a_ins = 34'd7;
      a_ins_valid = 1'b1;
      a_outs_ready = 1'b1;
      #1;
      check_eq("byp_ovalid", a_outs_valid, BYP ? 64'd1 : 64'd0);
      check_eq("byp_outs", a_outs, BYP ? 64'd7 : 64'd0);
      check_eq("byp_count0", a_count, 64'd0);
      @(posedge clk); #1;
      a_ins_valid = 1'b0;
      check_eq("byp_count1", a_count, BYP ? 64'd0 : 64'd1);
      drain_a();

      // Reset mid-stream with count 3
      a_outs_ready = 1'b0;
      for (int v = 0; v < 3; v++) push_a(34'h20 + 34'(v));
      check_eq("mid_pre_cnt", a_count, 64'd3);
      a_ins = 34'd0;
      rst = 1'b0;
      #1;
      check_eq("mid_count", a_count, 64'd0);
      check_eq("mid_ovalid", a_outs_valid, 64'd0);
      check_eq("mid_outs", a_outs, 64'd0);
      check_eq("mid_iready", a_ins_ready, 64'd1);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;

      // Wrap on 3 slots with random stalls
      fork
         begin
            for (int v = 0; v < 10; v++) push_b(34'h300 + 34'(v * 7));
            b_done = 1'b1;
         end
         begin
            for (int i = 0; i < 400; i++) begin
               @(posedge clk); #1;
               b_outs_ready = 1'($urandom_range(0, 1));
               if (b_done) break;
            end
         end
      join
      b_outs_ready = 1'b1;
      for (int i = 0; i < 40; i++) begin
         if (b_pops >= 10) break;
         @(posedge clk); #1;
      end
      check_eq("wrap_pops", b_pops, 64'd10);
      check_eq("wrap_max_ok", (b_max <= 3), 64'd1);
      check_eq("wrap_q_empty", b_q.size(), 64'd0);
      check_eq("a_q_empty", a_q.size(), 64'd0);

      $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
      $finish;
   end

endmodule
